// File: rtl/load_ext_ctrl_pkg.sv
// Shared definitions for the load extension controller: funct3 codes,
// FSM state encoding and the registered response payload.
package load_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned RD_WIDTH   = 5;
  localparam int unsigned F3_WIDTH   = 3;

  localparam logic [F3_WIDTH-1:0] F3_LB  = 3'd0;
  localparam logic [F3_WIDTH-1:0] F3_LH  = 3'd1;
  localparam logic [F3_WIDTH-1:0] F3_LW  = 3'd2;
  localparam logic [F3_WIDTH-1:0] F3_LBU = 3'd4;
  localparam logic [F3_WIDTH-1:0] F3_LHU = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RD_WIDTH-1:0]   rd;
    logic                  misalign;
    logic                  timeout;
  } resp_t;

  // True when funct3 is a supported load and the address suits its size.
  function automatic logic is_legal(input logic [F3_WIDTH-1:0] funct3,
                                    input logic [1:0]          addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~addr_lo[0];
      F3_LW:         ok = (addr_lo == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_ext_ctrl_if.sv
// Request, memory and response signals of the load controller.
// slave is the controller side, master is the surrounding pipeline/memory.
interface load_ext_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [4:0]            req_rd;

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [4:0]            resp_rd;
  logic                  resp_misalign;
  logic                  resp_timeout;

  logic                  busy;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd,
    input  mem_rdata, mem_rvalid,
    input  resp_ready,
    output req_ready,
    output mem_rd_en, mem_addr,
    output resp_valid, resp_data, resp_rd, resp_misalign, resp_timeout,
    output busy
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_rd,
    output mem_rdata, mem_rvalid,
    output resp_ready,
    input  req_ready,
    input  mem_rd_en, mem_addr,
    input  resp_valid, resp_data, resp_rd, resp_misalign, resp_timeout,
    input  busy
  );

endinterface

// File: rtl/load_ext_ctrl_lane_extender.sv
// Selects the byte/halfword lane of a read word and sign- or zero-extends
// it to 32 bits according to the load funct3.
module load_lane_extender
  import load_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_addr_lo,
  input  logic [F3_WIDTH-1:0]   i_funct3,
  output logic [DATA_WIDTH-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data_c = '0;
    case (i_funct3)
      F3_LB:   o_data_c = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data_c = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data_c = i_rdata;
      F3_LBU:  o_data_c = {24'h000000, w_byte};
      F3_LHU:  o_data_c = {16'h0000, w_half};
      default: o_data_c = '0;
    endcase
  end

endmodule

// File: rtl/load_ext_ctrl.sv
// Multi-cycle load controller: accepts one request, issues a single
// word-aligned read, extends the selected lane and returns it or a fault.
module load_ext_ctrl
  import load_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  load_ext_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]            r_state;
  logic [1:0]            r_addr_lo;
  logic [F3_WIDTH-1:0]   r_funct3;
  logic [RD_WIDTH-1:0]   r_rd;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_req_ready;
  logic                  r_busy;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_resp_valid;
  resp_t                 r_resp;

  logic [1:0]            w_next_state;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  resp_t                 w_resp_next;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_ext_data;

  load_lane_extender u_lane_extender (
    .i_rdata   (bus.mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data_c  (w_ext_data)
  );

  // Next state, counter and response payload; mem_rvalid only matters in WAIT.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_resp_next  = r_resp;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept = 1'b1;
          if (is_legal(bus.req_funct3, bus.req_addr[1:0])) begin
            w_next_state = ST_MEM;
          end else begin
            w_next_state         = ST_RESP;
            w_resp_next.data     = '0;
            w_resp_next.rd       = bus.req_rd;
            w_resp_next.misalign = 1'b1;
            w_resp_next.timeout  = 1'b0;
          end
        end
      end
      ST_MEM: begin
        w_cnt_next   = '0;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          w_next_state         = ST_RESP;
          w_resp_next.data     = w_ext_data;
          w_resp_next.rd       = r_rd;
          w_resp_next.misalign = 1'b0;
          w_resp_next.timeout  = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state         = ST_RESP;
          w_resp_next.data     = '0;
          w_resp_next.rd       = r_rd;
          w_resp_next.misalign = 1'b0;
          w_resp_next.timeout  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_next_state = ST_IDLE;
          w_resp_next  = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_resp_next  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr_lo    <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_cnt_next;
      r_resp       <= w_resp_next;
      r_req_ready  <= (w_next_state == ST_IDLE);
      r_busy       <= (w_next_state != ST_IDLE);
      r_mem_rd_en  <= (w_next_state == ST_MEM);
      r_resp_valid <= (w_next_state == ST_RESP);
      if (w_accept) begin
        r_addr_lo  <= bus.req_addr[1:0];
        r_funct3   <= bus.req_funct3;
        r_rd       <= bus.req_rd;
        r_mem_addr <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
      end
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.busy          = r_busy;
  assign bus.mem_rd_en     = r_mem_rd_en;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp.data;
  assign bus.resp_rd       = r_resp.rd;
  assign bus.resp_misalign = r_resp.misalign;
  assign bus.resp_timeout  = r_resp.timeout;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Scoreboard bench for load_ext_ctrl: directed cases followed by random
// loads checked against a behavioural load/extend model.
module tb_load_ext_ctrl;

  localparam int unsigned T = 64;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
    logic        to;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          dly;
  } plan_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic hold_rdy = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t  exp_q[$];
  plan_t plan_q[$];

  load_ext_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  load_ext_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T), .CNT_WIDTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  // Reference: legality from funct3 and address alignment.
  function automatic bit ref_legal(input logic [31:0] a, input logic [2:0] f);
    int k;
    k = int'(a[1:0]);
    case (f)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (k == 0) || (k == 2);
      3'd2:       return k == 0;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference: shift the word down to the addressed byte, mask, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f,
                                           input logic [31:0] w);
    logic [31:0] v;
    int k;
    k = int'(a[1:0]);
    v = 32'h0;
    case (f)
      3'd0, 3'd4: begin
        v = (w >> (8 * k)) & 32'h0000_00FF;
        if (f == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      3'd1, 3'd5: begin
        v = (w >> (8 * k)) & 32'h0000_FFFF;
        if (f == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
      end
      3'd2:    v = w;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic send(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] word, input int dly);
    exp_t  e;
    plan_t p;
    int    w;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_rd     = rd;
    w = 0;
    while (!bus.req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      fail_evt("req_accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    e.rd  = rd;
    e.acc = cyc + 1;
    e.mis = 1'b0;
    e.to  = 1'b0;
    if (!ref_legal(addr, f3)) begin
      e.data = 32'h0;
      e.mis  = 1'b1;
      e.lat  = 0;
    end else begin
      p.addr = addr;
      p.word = word;
      p.dly  = dly;
      plan_q.push_back(p);
      if (dly >= int'(T)) begin
        e.data = 32'h0;
        e.to   = 1'b1;
        e.lat  = int'(T) + 1;
      end else begin
        e.data = ref_load(addr, f3, word);
        e.lat  = 2 + dly;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0) && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || plan_q.size() != 0) fail_evt("drain_timeout");
  endtask

  // Response-ready driver, updated just after the edge.
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.resp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Memory model: answers each read after the planned number of WAIT cycles.
  initial begin
    plan_t p;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_rd_en) begin
        if (plan_q.size() == 0) begin
          fail_evt("unexpected_mem_read");
        end else begin
          p = plan_q.pop_front();
          chk("mem_addr", 64'(bus.mem_addr), 64'(p.addr & 32'hFFFF_FFFC));
          @(negedge clk);
          chk("mem_rd_en_single_pulse", 64'(bus.mem_rd_en), 64'd0);
          repeat (p.dly) @(negedge clk);
          bus.mem_rdata  = p.word;
          bus.mem_rvalid = 1'b1;
          @(negedge clk);
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = $urandom;
        end
      end
    end
  end

  // Monitor: latency on first assertion, stability while held, payload on handshake.
  initial begin
    exp_t e;
    logic        prev_v;
    logic [38:0] prev_pl;
    logic [38:0] pl;
    prev_v  = 1'b0;
    prev_pl = '0;
    forever begin
      @(negedge clk);
      pl = {bus.resp_data, bus.resp_rd, bus.resp_misalign, bus.resp_timeout};
      if (bus.resp_valid && !prev_v) begin
        if (exp_q.size() == 0) fail_evt("unexpected_resp_valid");
        else chk("resp_latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
        chk("req_ready_low_in_resp", 64'(bus.req_ready), 64'd0);
      end else if (bus.resp_valid && prev_v) begin
        chk("resp_stable", 64'(pl), 64'(prev_pl));
      end
      if (bus.resp_valid && bus.resp_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_data", 64'(bus.resp_data), 64'(e.data));
        chk("resp_rd", 64'(bus.resp_rd), 64'(e.rd));
        chk("resp_misalign", 64'(bus.resp_misalign), 64'(e.mis));
        chk("resp_timeout", 64'(bus.resp_timeout), 64'(e.to));
      end
      prev_v  = bus.resp_valid;
      prev_pl = pl;
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    logic [2:0]  f;
    int          d;
    int          n;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'd0;
    bus.req_rd     = 5'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_outputs", 64'({bus.resp_valid, bus.mem_rd_en, bus.busy,
                            bus.resp_misalign, bus.resp_timeout}), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    rst_n = 1'b1;

    w = 32'h80FF_1234;
    send(32'h1003, 3'd4, 5'd7,  w, 1);
    send(32'h1003, 3'd0, 5'd8,  w, 0);
    send(32'h1002, 3'd1, 5'd9,  w, 2);
    send(32'h1002, 3'd5, 5'd10, w, 0);
    send(32'h1000, 3'd2, 5'd11, w, 3);
    send(32'h1001, 3'd4, 5'd12, w, 0);
    send(32'h1002, 3'd2, 5'd13, w, 0);
    send(32'h1001, 3'd1, 5'd14, w, 0);
    send(32'h1000, 3'd3, 5'd15, w, 0);
    send(32'h1000, 3'd7, 5'd16, w, 0);
    send(32'h1004, 3'd2, 5'd17, 32'hCAFE_F00D, int'(T) - 1);
    send(32'h1008, 3'd2, 5'd18, 32'h1234_5678, int'(T) + 4);
    wait_drain(400);
    repeat (10) @(negedge clk);
    chk("stray_rvalid_idle", 64'({bus.resp_valid, bus.busy}), 64'd0);

    // Response held off: payload and req_ready frozen, new request refused.
    hold_rdy = 1'b1;
    send(32'h2000, 3'd2, 5'd20, 32'hA5A5_5A5A, 0);
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_resp_seen", 64'(bus.resp_valid), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h2001;
    bus.req_funct3 = 3'd4;
    repeat (5) begin
      @(negedge clk);
      chk("hold_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold_no_read", 64'(bus.mem_rd_en), 64'd0);
    end
    bus.req_valid = 1'b0;
    hold_rdy = 1'b0;
    wait_drain(100);

    // Reset in the middle of WAIT abandons the load.
    send(32'h3000, 3'd2, 5'd21, 32'h1111_2222, 6);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("midrst_outputs", 64'({bus.resp_valid, bus.mem_rd_en, bus.busy}), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_late_rvalid_ignored", 64'({bus.resp_valid, bus.busy}), 64'd0);
    send(32'h3004, 3'd2, 5'd22, 32'h3333_4444, 1);
    wait_drain(100);

    for (int i = 0; i < 60; i++) begin
      a = {16'h0, 16'($urandom)};
      f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) + (($urandom_range(0, 1) == 1) ? 3'd0 : 3'd4)
                                     : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       d = int'(T) - 1;
        1:       d = int'(T);
        2:       d = $urandom_range(6, 40);
        default: d = $urandom_range(0, 5);
      endcase
      send(a, f, 5'($urandom), $urandom, d);
    end
    wait_drain(3000);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_ext_ctrl.md
Name: load_ext_ctrl

Overview:
- Multi-cycle load controller between the execute stage and data memory.
- Accepts one load request at a time, issues a single word-aligned memory read, then selects the byte, halfword or word lane.
- Zero- or sign-extends the selected lane to 32 bits per funct3 and returns it with the destination register.
- Raises misalignment and timeout faults instead of writing back.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT_CYCLES, 64, WAIT cycles without mem_rvalid before a fault is returned; must be ≥2.
- CNT_WIDTH, 7, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_addr  in  ADDR_WIDTH  byte address
- req_funct3  in  3  RV32I load funct3
- req_rd  in  5  destination register
- mem_rd_en  out  1  one-cycle read strobe
- mem_addr  out  ADDR_WIDTH  word-aligned read address
- mem_rdata  in  32  read word
- mem_rvalid  in  1  read data valid
- resp_valid  out  1  response held until taken
- resp_ready  in  1  writeback accepts response
- resp_data  out  32  extended load result
- resp_rd  out  5  destination register
- resp_misalign  out  1  address misaligned or funct3 illegal
- resp_timeout  out  1  memory did not answer
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All outputs 0 except req_ready = 1.
  - Timeout counter and captured request registers cleared.
  - Reset mid-operation abandons the transaction; a late mem_rvalid after reset is ignored.
- States: IDLE, MEM, WAIT, RESP.
- IDLE:
  - Accept when req_valid & req_ready; latch addr, funct3 and rd.
  - Legality check:
    - funct3 3, 6 or 7 is illegal.
    - LH/LHU (1, 5) with addr[0] = 1 is misaligned.
    - LW (2) with addr[1:0] != 0 is misaligned.
  - Illegal or misaligned → RESP with resp_misalign = 1, resp_data = 0, no memory access.
  - Otherwise → MEM.
- MEM:
  - mem_rd_en = 1 for exactly this cycle; mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Clear the timeout counter; → WAIT.
  - mem_rvalid in this cycle is ignored.
- WAIT:
  - On mem_rvalid: capture the extended result; → RESP.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES-1 without mem_rvalid → RESP with resp_timeout = 1, resp_data = 0.
  - mem_rvalid in the same cycle as timeout expiry wins (data returned, no fault).
- RESP:
  - resp_valid = 1; resp_* registered and stable until resp_valid & resp_ready → IDLE.
  - req_ready is 0 in RESP, so back-to-back requests see one IDLE cycle minimum.
  - mem_rvalid outside WAIT is ignored.
- Lane select and extension:
  - Byte lane k = addr[1:0] selects mem_rdata[8k+7:8k].
  - Half lane addr[1] selects mem_rdata[15:0] or [31:16].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-fill upper bits; LW passes through.
- Latency: accept edge → MEM (1 cycle) → WAIT; resp_valid asserts the cycle after mem_rvalid. Best case is 3 cycles from accept to resp_valid; misaligned requests give resp_valid 1 cycle after accept.
- Exactly one of {normal, resp_misalign, resp_timeout} per response.

Decomposition:
- Shared package load_pkg:
  - funct3 constants F3_LB = 0, F3_LH = 1, F3_LW = 2, F3_LBU = 4, F3_LHU = 5.
  - State encoding IDLE = 0, MEM = 1, WAIT = 2, RESP = 3.
- One combinational sub-module, load_lane_extender: (rdata[31:0], addr_lo[1:0], funct3) → data[31:0]. Performs lane select plus sign/zero fill and is instantiated once in the WAIT capture path.

Test Plan:
- LBU addr 0x1003, mem_rdata 0x80FF_1234 → resp_data 0x0000_0080, resp_rd echoed, mem_addr 0x1000, one mem_rd_en pulse.
- LB addr 0x1003, same data → 0xFFFF_FF80; LH addr 0x1002 → 0xFFFF_80FF; LHU addr 0x1002 → 0x0000_80FF; LW addr 0x1000 → 0x80FF_1234.
- LW addr 0x1002 and LH addr 0x1001 → resp_misalign = 1, resp_data = 0, mem_rd_en never asserted, resp_valid 1 cycle after accept; funct3 = 3 → resp_misalign = 1.
- mem_rvalid never asserted → resp_timeout = 1 after TIMEOUT_CYCLES WAIT cycles; a later stray mem_rvalid in IDLE causes no response.
- resp_ready held low 5 cycles → resp_valid and resp_data stable throughout, req_ready = 0, new req_valid not accepted until handshake completes.
- rst_n pulsed low during WAIT → all outputs reset immediately, req_ready = 1; subsequent mem_rvalid ignored; next LW completes normally.
